// File: rtl/fpm_pkg.sv
// Shared types and constants for the sign-magnitude fixed-point multiplier and its arbiter.
package fpm_pkg;

  typedef logic [15:0] fx16_t;
  typedef logic [31:0] fx32_t;

  localparam int unsigned FX_FRAC_IN  = 12;
  localparam int unsigned FX_FRAC_OUT = 24;
  localparam int unsigned FX_SIGN_IN  = 15;
  localparam int unsigned FX_SIGN_OUT = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // A product with zero magnitude always carries a positive sign.
  function automatic fx32_t fx_fix_neg_zero(fx32_t p);
    fx32_t r;
    r = p;
    if (p[FX_SIGN_OUT-1:0] == '0) begin
      r[FX_SIGN_OUT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_point_mult.sv
// Combinational sign-magnitude multiply: Q3.12 x Q3.12 -> Q7.24 with the sign in bit 31.
module fixed_point_mult
  import fpm_pkg::*;
(
  input  fx16_t i_a,
  input  fx16_t i_b,
  output fx32_t o_p
);

  logic [29:0] w_mag;

  assign w_mag = 30'(i_a[14:0]) * 30'(i_b[14:0]);
  assign o_p   = {i_a[FX_SIGN_IN] ^ i_b[FX_SIGN_IN], 1'b0, w_mag};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid requester at or above the pointer, wrapping at NUM_REQ-1.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_cand;
  logic            w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // Explicit subtract keeps the wrap correct for non-power-of-two NUM_REQ.
      w_sum = {1'b0, i_ptr} + (ID_W + 1)'(k);
      if (w_sum >= (ID_W + 1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_W + 1)'(NUM_REQ);
      end
      w_cand = w_sum[ID_W-1:0];
      if (!w_found && i_valid[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/fixed_point_mult_arbiter.sv
// Shares one fixed_point_mult among NUM_REQ requesters with round-robin grant and a
// held valid/ready response tagged with the owning requester.
module fixed_point_mult_arbiter
  import fpm_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  busy,
  output logic [15:0]           op_count
);

  arb_state_t      r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_id_q;
  logic [ID_W-1:0] r_rsp_id;
  fx16_t           r_a_q;
  fx16_t           r_b_q;
  fx32_t           r_rsp_result;
  logic [15:0]     r_op_count;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_any;
  fx16_t              w_sel_a;
  fx16_t              w_sel_b;
  fx32_t              w_prod;
  logic [ID_W-1:0]    w_next_ptr;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .i_valid(req_valid),
    .i_ptr  (r_rr_ptr),
    .o_grant(w_grant),
    .o_idx  (w_grant_idx),
    .o_any  (w_any)
  );

  fixed_point_mult u_fixed_point_mult (
    .i_a(r_a_q),
    .i_b(r_b_q),
    .o_p(w_prod)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == ID_W'(i)) begin
        w_sel_a = req_a[16*i +: 16];
        w_sel_b = req_b[16*i +: 16];
      end
    end
  end

  assign w_next_ptr = (r_id_q == ID_W'(NUM_REQ - 1)) ? '0 : r_id_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_id_q       <= '0;
      r_rsp_id     <= '0;
      r_a_q        <= '0;
      r_b_q        <= '0;
      r_rsp_result <= '0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a_q   <= w_sel_a;
            r_b_q   <= w_sel_b;
            r_id_q  <= w_grant_idx;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_rsp_result <= fx_fix_neg_zero(w_prod);
          r_rsp_id     <= r_id_q;
          r_state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rr_ptr   <= w_next_ptr;
            r_op_count <= r_op_count + 16'd1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Grant strobe is combinational so a requester sees acceptance on the same edge it is latched.
  assign req_ready  = (r_state == IDLE && !rst) ? w_grant : '0;
  assign rsp_valid  = (r_state == RESP);
  assign busy       = (r_state != IDLE);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_fixed_point_mult_arbiter.sv
// Directed vector table, reset/wrap sequences and randomized traffic against a behavioural model.
module tb_fixed_point_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_result;
  logic        busy;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  int model_cnt = 0;

  fixed_point_mult_arbiter #(
    .NUM_REQ(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  typedef struct packed {
    logic        rst_before;
    logic [3:0]  v;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  id;
    logic [31:0] res;
    logic [3:0]  hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (ptr + k) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_mult(input logic [15:0] a, input logic [15:0] b);
    int unsigned mag;
    logic        s;
    mag = int'(a & 16'h7fff) * int'(b & 16'h7fff);
    s   = (a[15] != b[15]) && (mag != 0);
    return {s, mag[30:0]};
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    model_ptr = 0;
    model_cnt = 0;
  endtask

  // Called at a negedge in IDLE with requests already driven; returns at a negedge in IDLE.
  task automatic do_op(input int g, input logic [31:0] er, input int hold);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    rsp_ready = 1'b0;
    #1;
    chk("req_ready_grant", {28'b0, req_ready}, {28'b0, oh});
    chk("busy_idle", {31'b0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid_calc", {31'b0, rsp_valid}, 32'd0);
    chk("req_ready_calc", {28'b0, req_ready}, 32'd0);
    chk("busy_calc", {31'b0, busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid_resp", {31'b0, rsp_valid}, 32'd1);
    chk("rsp_id", {30'b0, rsp_id}, 32'(g));
    chk("rsp_result", rsp_result, er);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_id", {30'b0, rsp_id}, 32'(g));
      chk("hold_result", rsp_result, er);
      chk("hold_req_ready", {28'b0, req_ready}, 32'd0);
      chk("hold_busy", {31'b0, busy}, 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    model_ptr = (g + 1) % 4;
    model_cnt = (model_cnt + 1) % 65536;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_fall", {31'b0, rsp_valid}, 32'd0);
    chk("busy_done", {31'b0, busy}, 32'd0);
    chk("op_count", {16'b0, op_count}, 32'(model_cnt));
  endtask

  vec_t       tbl[9];
  logic [3:0] v;
  logic [15:0] ra[4];
  logic [15:0] rb[4];

  initial begin
    tbl[0] = '{1'b0, 4'b0001, 64'h0000_0000_0000_0800, 64'h0000_0000_0000_0800,
               2'd0, 32'h0040_0000, 4'd0};
    tbl[1] = '{1'b0, 4'b0100, 64'h0000_8800_0000_0000, 64'h0000_0800_0000_0000,
               2'd2, 32'h8040_0000, 4'd0};
    tbl[2] = '{1'b0, 4'b0100, 64'h0000_8800_0000_0000, 64'h0000_8800_0000_0000,
               2'd2, 32'h0040_0000, 4'd1};
    tbl[3] = '{1'b0, 4'b0100, 64'h0000_8000_0000_0000, 64'h0000_0800_0000_0000,
               2'd2, 32'h0000_0000, 4'd0};
    tbl[4] = '{1'b1, 4'b1111, 64'h0800_0800_0800_0800, 64'h8800_2000_0800_1000,
               2'd0, 32'h0080_0000, 4'd0};
    tbl[5] = '{1'b0, 4'b1111, 64'h0800_0800_0800_0800, 64'h8800_2000_0800_1000,
               2'd1, 32'h0040_0000, 4'd10};
    tbl[6] = '{1'b0, 4'b1111, 64'h0800_0800_0800_0800, 64'h8800_2000_0800_1000,
               2'd2, 32'h0100_0000, 4'd0};
    tbl[7] = '{1'b0, 4'b1111, 64'h0800_0800_0800_0800, 64'h8800_2000_0800_1000,
               2'd3, 32'h8040_0000, 4'd2};
    tbl[8] = '{1'b0, 4'b1111, 64'h0800_0800_0800_0800, 64'h8800_2000_0800_1000,
               2'd0, 32'h0080_0000, 4'd0};

    // Reset state
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_op_count", {16'b0, op_count}, 32'd0);
    chk("rst_rsp_id", {30'b0, rsp_id}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_no_req", {28'b0, req_ready}, 32'd0);
    @(negedge clk);

    for (int r = 0; r < 9; r++) begin
      if (tbl[r].rst_before) begin
        req_valid = '0;
        apply_reset();
      end
      req_valid = tbl[r].v;
      req_a     = tbl[r].a;
      req_b     = tbl[r].b;
      do_op(int'(tbl[r].id), tbl[r].res, int'(tbl[r].hold));
    end

    // Reset while in CALC: operation dropped, pointer back to requester 0.
    req_valid = 4'b0010;
    req_a     = 64'h0000_0000_1000_0000;
    req_b     = 64'h0000_0000_1000_0000;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_calc", {31'b0, busy}, 32'd1);
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_op_count", {16'b0, op_count}, 32'd0);
    chk("midrst_rsp_id", {30'b0, rsp_id}, 32'd0);
    chk("midrst_rsp_result", rsp_result, 32'd0);
    chk("midrst_req_ready", {28'b0, req_ready}, 32'd0);
    rst       = 1'b0;
    model_ptr = 0;
    model_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_no_pulse", {31'b0, rsp_valid}, 32'd0);
    end
    req_valid = 4'b1111;
    req_a     = 64'h0800_0800_0800_0800;
    req_b     = 64'h8800_2000_0800_1000;
    do_op(0, 32'h0080_0000, 0);

    // Counter wrap
    req_valid = '0;
    force dut.r_op_count = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.r_op_count;
    model_cnt = 16'hFFFF;
    @(negedge clk);
    chk("wrap_preload", {16'b0, op_count}, 32'h0000_FFFF);
    req_valid = 4'b0100;
    req_a     = 64'h0000_0800_0000_0000;
    req_b     = 64'h0000_0800_0000_0000;
    do_op(model_grant(4'b0100, model_ptr), 32'h0040_0000, 0);
    chk("wrap_zero", {16'b0, op_count}, 32'd0);

    // Randomized traffic
    v = '0;
    for (int i = 0; i < 4; i++) begin
      ra[i] = '0;
      rb[i] = '0;
    end
    for (int n = 0; n < 80; n++) begin
      int g;
      for (int i = 0; i < 4; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i]  = 1'b1;
          ra[i] = 16'($urandom);
          rb[i] = 16'($urandom);
          if ($urandom_range(0, 7) == 0) ra[i][14:0] = '0;
        end else if (v[i] && $urandom_range(0, 9) == 0) begin
          v[i] = 1'b0;
        end
      end
      if (v == '0) begin
        v[n % 4]  = 1'b1;
        ra[n % 4] = 16'($urandom);
        rb[n % 4] = 16'($urandom);
      end
      req_valid = v;
      req_a     = {ra[3], ra[2], ra[1], ra[0]};
      req_b     = {rb[3], rb[2], rb[1], rb[0]};
      g = model_grant(v, model_ptr);
      do_op(g, model_mult(ra[g], rb[g]), int'($urandom_range(0, 3)));
      v[g] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
